// File: rtl/vram_loader.sv
// vram_loader: Z80-bus write master that fills the 1 KiB tile VRAM window
// from a byte stream. It issues one write per accepted byte and honours the
// video block's vram_busy back-pressure. The 10-bit window offset
// auto-increments and wraps, and the block reports completion with a pulse.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous reset, active HIGH (legacy name)
//   start      one-cycle pulse; latches first_off/count when idle
//   first_off  starting window offset (10b)
//   count      bytes to write, 0..1024 (11b)
//   abort      cancel the running transfer (no done pulse)
//   s_valid    source byte valid
//   s_data     source byte
//   s_ready    byte taken on an edge where s_valid & s_ready
//   vram_busy  video block stall; no write is issued while high
//   bus_addr   BASE_ADDR + offset
//   bus_dout   write data
//   bus_wrn    active-low write strobe, low one cycle per byte
//   bus_rdn    constant 1 (write-only master)
//   busy       transfer in progress
//   done       one-cycle completion pulse
module vram_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h7400
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [9:0]  first_off,
  input  logic [10:0] count,
  input  logic        abort,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  input  logic        vram_busy,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  output logic        bus_wrn,
  output logic        bus_rdn,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic [9:0]  offset;
  logic [10:0] remain;
  logic [10:0] total;
  logic [10:0] accepted;
  logic        hold_v;
  logic [7:0]  hold_d;
  logic        commit;
  logic        accept;

  // The held byte goes out on any cycle the video block is not stalling us.
  assign commit = (state == S_RUN) && hold_v && !vram_busy;

  // The hold register can refill on the same edge it drains. This gives
  // 1 byte/cycle sustained. The accepted < total term stops the block from
  // taking more bytes than it will write.
  assign s_ready = (state == S_RUN) && (!hold_v || commit) && (accepted < total);
  assign accept  = s_valid && s_ready;

  assign bus_rdn = 1'b1;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state    <= S_IDLE;
      offset   <= '0;
      remain   <= '0;
      total    <= '0;
      accepted <= '0;
      hold_v   <= 1'b0;
      hold_d   <= '0;
      bus_addr <= BASE_ADDR;
      bus_dout <= '0;
      bus_wrn  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // The strobe and the completion pulse are single-cycle by default.
      bus_wrn <= 1'b1;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            offset   <= first_off;
            remain   <= count;
            total    <= count;
            accepted <= '0;
            hold_v   <= 1'b0;
            // An empty transfer skips RUN and generates no bus activity.
            state    <= (count == 11'd0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            // Abort takes priority over any commit pending this edge.
            state  <= S_IDLE;
            busy   <= 1'b0;
            hold_v <= 1'b0;
          end else begin
            if (commit) begin
              bus_wrn  <= 1'b0;
              bus_addr <= BASE_ADDR + {6'd0, offset};
              bus_dout <= hold_d;
              offset   <= offset + 10'd1;  // natural 10-bit wrap
              remain   <= remain - 11'd1;
              if (remain == 11'd1) state <= S_DONE;
            end
            if (accept) begin
              hold_v   <= 1'b1;
              hold_d   <= s_data;
              accepted <= accepted + 11'd1;
            end else if (commit) begin
              hold_v <= 1'b0;
            end
          end
        end
        S_DONE: begin
          // busy falls on the same edge that done rises.
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_loader.sv
module tb_vram_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, s_valid, vram_busy;
  logic [9:0]  first_off;
  logic [10:0] count;
  logic [7:0]  s_data;
  logic        s_ready;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        bus_wrn, bus_rdn, busy, done;

  vram_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .first_off(first_off),
    .count(count), .abort(abort), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .vram_busy(vram_busy), .bus_addr(bus_addr),
    .bus_dout(bus_dout), .bus_wrn(bus_wrn), .bus_rdn(bus_rdn),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic last_busy = 1'b0;

  // Scoreboard state.
  logic [23:0] exp_q[$];
  int n_wr = 0, n_done = 0;
  int first_wr_cyc = -1, last_wr_cyc = -1, done_cyc = -1;
  logic busy_at_done = 1'b0;

  logic [7:0] src [0:1023];

  // Per-transfer results from xfer.
  int t_fires, t_busy_low, t_start_cyc, wr0, d0;
  bit t_fin;

  always @(posedge clk) begin
    cyc = cyc + 1;
    last_busy = vram_busy;  // vram_busy only changes at negedge
  end

  // Monitor: each write strobe pops one expected {addr,data}. The write must
  // not follow a cycle in which vram_busy was high.
  always @(negedge clk) begin
    logic [23:0] e;
    if (bus_wrn === 1'b0) begin
      n_wr = n_wr + 1;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        failures = failures + 1;
        $display("FAIL write_unexpected actual addr=%h data=%h", bus_addr, bus_dout);
      end else begin
        e = exp_q.pop_front();
        if ({bus_addr, bus_dout} !== e || last_busy) begin
          failures = failures + 1;
          $display("FAIL write actual addr=%h data=%h busy_prev=%0b expected addr=%h data=%h",
                   bus_addr, bus_dout, last_busy, e[23:8], e[7:0]);
        end
      end
    end
    if (done === 1'b1) begin
      n_done = n_done + 1;
      done_cyc = cyc;
      busy_at_done = busy;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wrn"},   bus_wrn,  1);
    chk({tag, "_rdn"},   bus_rdn,  1);
    chk({tag, "_addr"},  bus_addr, 32'h7400);
    chk({tag, "_dout"},  bus_dout, 0);
    chk({tag, "_busy"},  busy,     0);
    chk({tag, "_done"},  done,     0);
    chk({tag, "_ready"}, s_ready,  0);
  endtask

  // Runs one transfer cycle by cycle. Accepted bytes are pushed to the
  // scoreboard with their expected window address. The task returns at the
  // negedge where done is seen, or where abort/reset was issued.
  task automatic xfer(input logic [9:0] off, input logic [10:0] cnt, input bit rand_busy,
                      input int abort_at, input int start2_at, input int reset_at);
    int idx = 0;
    bit fire;
    bit s2 = 0;
    t_fires = 0; t_busy_low = 0; t_fin = 0;
    first_wr_cyc = -1;
    wr0 = n_wr; d0 = n_done;
    @(negedge clk);
    s_valid = 0; vram_busy = 0;
    first_off = off; count = cnt; start = 1; t_start_cyc = cyc;
    for (int k = 0; k < 5000 && !t_fin; k++) begin
      @(negedge clk);
      vram_busy = rand_busy ? ($urandom_range(0, 2) == 0) : 1'b0;
      s_valid = (idx < int'(cnt));
      s_data = (idx < 1024) ? src[idx] : 8'h00;
      start = 0; abort = 0;
      #1;
      if (abort_at > 0 && n_wr - wr0 >= abort_at) begin abort = 1; t_fin = 1; end
      if (start2_at > 0 && !s2 && n_wr - wr0 == start2_at) begin
        start = 1; first_off = 10'h100; count = 11'd3; s2 = 1;
      end
      if (reset_at > 0 && n_wr - wr0 >= reset_at) begin rst_n = 1; t_fin = 1; end
      if (n_done != d0) t_fin = 1;
      if (!t_fin && busy !== 1'b1) t_busy_low++;
      fire = s_valid && (s_ready === 1'b1);
      if (fire) begin
        exp_q.push_back({16'h7400 + 16'((int'(off) + idx) % 1024), src[idx]});
        idx++;
        t_fires++;
      end
    end
    chk("xfer_no_timeout", t_fin, 1);
  endtask

  task automatic idle_inputs();
    start = 0; abort = 0; s_valid = 0; vram_busy = 0; s_data = 0;
  endtask

  task automatic check_normal_end(input string tag, input int n);
    chk({tag, "_fires"},     t_fires, n);
    chk({tag, "_writes"},    n_wr - wr0, n);
    chk({tag, "_done_lat"},  done_cyc, last_wr_cyc + 1);
    chk({tag, "_busy_thru"}, t_busy_low, 0);
    chk({tag, "_busy_fall"}, busy_at_done, 0);
    chk({tag, "_q_empty"},   exp_q.size(), 0);
  endtask

  initial begin
    rst_n = 1; first_off = 0; count = 0;
    idle_inputs();
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 0;
    repeat (2) @(negedge clk);

    // T1: 960 bytes from offset 0x040, no stalls.
    for (int j = 0; j < 1024; j++) src[j] = 8'(j % 10);
    xfer(10'h040, 11'd960, 0, 0, 0, 0);
    idle_inputs();
    check_normal_end("t1", 960);
    chk("t1_first_lat", first_wr_cyc, t_start_cyc + 3);
    chk("t1_span", last_wr_cyc - first_wr_cyc, 959);
    repeat (2) @(negedge clk);

    // T2: same transfer under random vram_busy.
    xfer(10'h040, 11'd960, 1, 0, 0, 0);
    idle_inputs();
    check_normal_end("t2", 960);
    repeat (2) @(negedge clk);

    // T3: wrap from 0x3FE; expected 77FE, 77FF, 7400, 7401.
    src[0] = 8'hA1; src[1] = 8'hA2; src[2] = 8'hA3; src[3] = 8'hA4;
    xfer(10'h3FE, 11'd4, 0, 0, 0, 0);
    idle_inputs();
    check_normal_end("t3", 4);
    chk("t3_last_addr", bus_addr, 32'h7401);
    repeat (2) @(negedge clk);

    // T4: count 0 gives done 2 cycles after start, no bus activity.
    xfer(10'h123, 11'd0, 0, 0, 0, 0);
    idle_inputs();
    chk("t4_done_lat", done_cyc - t_start_cyc, 2);
    chk("t4_no_ready", t_fires, 0);
    chk("t4_no_write", n_wr - wr0, 0);
    repeat (2) @(negedge clk);

    // T5: count 16, abort after 5 writes.
    for (int j = 0; j < 16; j++) src[j] = 8'h30 + 8'(j);
    xfer(10'h200, 11'd16, 0, 5, 0, 0);
    @(negedge clk);
    idle_inputs();
    chk("t5_busy_after_abort", busy, 0);
    chk("t5_wrn_after_abort", bus_wrn, 1);
    repeat (10) @(negedge clk);
    chk("t5_writes", n_wr - wr0, 5);
    chk("t5_no_done", n_done - d0, 0);
    exp_q.delete();
    xfer(10'h010, 11'd4, 0, 0, 0, 0);
    idle_inputs();
    check_normal_end("t5_restart", 4);
    repeat (2) @(negedge clk);

    // T6: count 8, ignored start after 2 writes, reset after 3 writes.
    for (int j = 0; j < 8; j++) src[j] = 8'h50 + 8'(j);
    xfer(10'h080, 11'd8, 0, 0, 2, 3);
    #1;
    chk_reset_outputs("t6_async");
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 0;
    exp_q.delete();
    repeat (8) @(negedge clk);
    chk("t6_writes", n_wr - wr0, 3);
    chk("t6_no_done", n_done - d0, 0);
    chk("t6_idle_busy", busy, 0);

    // T7: normal run after reset.
    for (int j = 0; j < 3; j++) src[j] = 8'hC0 + 8'(j);
    xfer(10'h3FF, 11'd3, 1, 0, 0, 0);
    idle_inputs();
    check_normal_end("t7", 3);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
